detect_faces_mul_arbiter: RTL and testbench

- Shares one unsigned 16x9 -> 24 multiplier among NUM_REQ requesters in the detectFaces datapath, e.g. Haar-feature weight x rectangle-sum scaling lanes.
- Uses a round-robin grant with valid/ready handshakes on both sides.
- Registered output: one product per cycle at full throughput.
- Sits between the per-lane feature evaluators and the stage-sum accumulator.

---
 rtl/detect_faces_mul_pkg.sv | 19 +
 rtl/detect_faces_rr_pick.sv | 30 +++
 rtl/detect_faces_mul_arbiter.sv | 134 +++++++++++++
 tb/tb_detect_faces_mul_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/detect_faces_mul_pkg.sv
// Shared widths, id-width helper and output-stage state for the detectFaces multiplier arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package detect_faces_mul_pkg;

    localparam int DF_A_WIDTH = 16;
    localparam int DF_B_WIDTH = 9;
    localparam int DF_P_WIDTH = 24;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_st_e;

endpackage

// File: rtl/detect_faces_rr_pick.sv
// Round-robin picker: first requester at or after i_ptr, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; the caller qualifies the grant with its own accept.
module detect_faces_rr_pick
    import detect_faces_mul_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!o_any && i_req[(int'(i_ptr) + k) % N]) begin
                o_any                           = 1'b1;
                o_grant[(int'(i_ptr) + k) % N]  = 1'b1;
                o_idx                           = IDW'((int'(i_ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/detect_faces_mul_arbiter.sv
// Round-robin share of one 16x9 multiplier among NUM_REQ lanes; optional operand stage via DETECT_FACES_MUL_IN_REG_EN.
// Latency: 1 cycle accept->rsp_valid (2 with DETECT_FACES_MUL_IN_REG_EN); one product per cycle.
// Backpressure: rsp_ready=0 with a full pipe drops req_ready to zero in the same cycle; pointer moves only on transfer.
module detect_faces_mul_arbiter
    import detect_faces_mul_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int A_WIDTH  = DF_A_WIDTH,
    parameter int B_WIDTH  = DF_B_WIDTH,
    parameter int P_WIDTH  = DF_P_WIDTH,
    parameter int ID_WIDTH = id_width(NUM_REQ)
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_WIDTH-1:0]          rsp_id,
    output logic [P_WIDTH-1:0]           rsp_p,
    output logic                         busy
);

    logic [ID_WIDTH-1:0] r_ptr;
    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_WIDTH-1:0] w_idx;
    logic                w_any;
    logic                w_can_accept;
    logic                w_xfer;
    logic                w_out_adv;
    logic                w_ld_out;
    out_st_e             r_out_st;
    out_st_e             w_out_st_nxt;
    logic [A_WIDTH-1:0]  w_sel_a;
    logic [B_WIDTH-1:0]  w_sel_b;
    logic [A_WIDTH-1:0]  w_mul_a;
    logic [B_WIDTH-1:0]  w_mul_b;
    logic [ID_WIDTH-1:0] w_mul_id;
    logic [P_WIDTH-1:0]  w_prod;
    logic [P_WIDTH-1:0]  r_rsp_p;
    logic [ID_WIDTH-1:0] r_rsp_id;

    detect_faces_rr_pick #(
        .N   (NUM_REQ),
        .IDW (ID_WIDTH)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_sel_a   = req_a[w_idx*A_WIDTH +: A_WIDTH];
    assign w_sel_b   = req_b[w_idx*B_WIDTH +: B_WIDTH];
    assign rsp_valid = (r_out_st == ST_FULL);
    assign w_out_adv = !rsp_valid || rsp_ready;
    assign w_xfer    = w_any && w_can_accept;
    assign req_ready = w_grant & {NUM_REQ{w_can_accept}};

`ifdef DETECT_FACES_MUL_IN_REG_EN
    logic                r_s0_vld;
    logic [A_WIDTH-1:0]  r_s0_a;
    logic [B_WIDTH-1:0]  r_s0_b;
    logic [ID_WIDTH-1:0] r_s0_id;

    // Stage 0 refills whenever it is empty or its content moves on this cycle.
    assign w_can_accept = !r_s0_vld || w_out_adv;
    assign w_ld_out     = r_s0_vld && w_out_adv;
    assign w_mul_a      = r_s0_a;
    assign w_mul_b      = r_s0_b;
    assign w_mul_id     = r_s0_id;
    assign busy         = r_s0_vld || rsp_valid;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_s0_vld <= 1'b0;
            r_s0_a   <= '0;
            r_s0_b   <= '0;
            r_s0_id  <= '0;
        end else if (w_can_accept) begin
            r_s0_vld <= w_xfer;
            if (w_xfer) begin
                r_s0_a  <= w_sel_a;
                r_s0_b  <= w_sel_b;
                r_s0_id <= w_idx;
            end
        end
    end
`else
    assign w_can_accept = w_out_adv;
    assign w_ld_out     = w_xfer;
    assign w_mul_a      = w_sel_a;
    assign w_mul_b      = w_sel_b;
    assign w_mul_id     = w_idx;
    assign busy         = rsp_valid;
`endif

    // Full-width product, truncated to P_WIDTH with no saturation.
    assign w_prod = P_WIDTH'({{B_WIDTH{1'b0}}, w_mul_a} * {{A_WIDTH{1'b0}}, w_mul_b});

    always_comb begin
        w_out_st_nxt = r_out_st;
        if (w_ld_out) begin
            w_out_st_nxt = ST_FULL;
        end else if (rsp_ready) begin
            w_out_st_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_out_st <= ST_EMPTY;
            r_rsp_p  <= '0;
            r_rsp_id <= '0;
            r_ptr    <= '0;
        end else begin
            r_out_st <= w_out_st_nxt;
            if (w_ld_out) begin
                r_rsp_p  <= w_prod;
                r_rsp_id <= w_mul_id;
            end
            if (w_xfer) begin
                r_ptr <= (w_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
            end
        end
    end

    assign rsp_p  = r_rsp_p;
    assign rsp_id = r_rsp_id;

endmodule

// File: tb/tb_detect_faces_mul_arbiter.sv
// Bench for detect_faces_mul_arbiter: directed scenarios plus random traffic against a queue-based reference.
module tb_detect_faces_mul_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int BW = 9;
    localparam int PW = 24;
    localparam int IW = 2;
`ifdef DETECT_FACES_MUL_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_a = '0;
    logic [N*BW-1:0]   req_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IW-1:0]     rsp_id;
    logic [PW-1:0]     rsp_p;
    logic              busy;

    detect_faces_mul_arbiter dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .busy      (busy)
    );

    always #5 ap_clk = ~ap_clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint ref_prod(input longint a, input longint b);
        return (a * b) & ((64'sd1 <<< PW) - 1);
    endfunction

    // Reference: in-order queue of accepted products plus per-stage occupancy flags.
    typedef struct {
        int     id;
        longint p;
    } item_t;

    item_t q[$];
    bit    m_v[LAT];
    int    m_ptr = 0;
    int    wait_cnt[N];

    always @(negedge ap_clk) begin : cmp
        int           g;
        bit           ok[LAT+1];
        bit           xf;
        bit           be;
        logic [N-1:0] exp_rdy;
        if (!ap_rst_n) begin
            q.delete();
            for (int s = 0; s < LAT; s++) m_v[s] = 1'b0;
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
            m_ptr = 0;
            chk("reset_rsp_valid", rsp_valid == 1'b0, rsp_valid, 0);
            chk("reset_busy", busy == 1'b0, busy, 0);
            chk("reset_rsp_p", rsp_p == '0, rsp_p, 0);
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            ok[LAT] = rsp_ready;
            for (int s = LAT - 1; s >= 0; s--) ok[s] = !m_v[s] || ok[s+1];
            xf      = (g >= 0) && ok[0];
            exp_rdy = xf ? N'(1) << g : '0;
            be      = 1'b0;
            for (int s = 0; s < LAT; s++) be |= m_v[s];
            chk("req_ready", req_ready == exp_rdy, req_ready, exp_rdy);
            chk("rsp_valid", rsp_valid == m_v[LAT-1], rsp_valid, m_v[LAT-1]);
            chk("busy", busy == be, busy, be);
            if (m_v[LAT-1]) begin
                if (q.size() == 0) begin
                    chk("queue_underflow", 1'b0, 0, 1);
                end else begin
                    chk("rsp_id", rsp_id == IW'(q[0].id), rsp_id, q[0].id);
                    chk("rsp_p", rsp_p == PW'(q[0].p), rsp_p, q[0].p);
                end
                if (rsp_ready && q.size() > 0) void'(q.pop_front());
            end
            if (xf) begin
                for (int i = 0; i < N; i++) begin
                    if (i == g) begin
                        wait_cnt[i] = 0;
                    end else if (req_valid[i]) begin
                        wait_cnt[i]++;
                        chk("fairness", wait_cnt[i] < N, wait_cnt[i], N - 1);
                    end
                end
                q.push_back('{g, ref_prod(longint'(req_a[g*AW +: AW]), longint'(req_b[g*BW +: BW]))});
                m_ptr = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) if (!req_valid[i]) wait_cnt[i] = 0;
            for (int s = LAT - 1; s >= 0; s--) begin
                if (ok[s]) begin
                    if (s == 0) m_v[s] = xf;
                    else        m_v[s] = m_v[s-1];
                end
            end
        end
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        ap_rst_n = 1'b0;
        step();
        ap_rst_n = 1'b1;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (LAT + 1) step();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [N-1:0] t4_vld[4];
        logic [N-1:0] t4_exp[4];
        t4_vld = '{4'b1011, 4'b1001, 4'b1001, 4'b1001};
        t4_exp = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};

        repeat (2) step();
        ap_rst_n = 1'b1;

        // Single request, worst-case operands.
        req_a[2*AW +: AW] = 16'hFFFF;
        req_b[2*BW +: BW] = 9'h1FF;
        req_valid = 4'b0100;
        @(negedge ap_clk);
        chk("t1_ready", req_ready == 4'b0100, req_ready, 4'b0100);
        step();
        req_valid = '0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge ap_clk);
            chk("t1_latency", rsp_valid == (k == LAT), rsp_valid, (k == LAT));
            if (k == LAT) begin
                chk("t1_id", rsp_id == 2'd2, rsp_id, 2);
                chk("t1_prod", rsp_p == 24'hFEFE01, rsp_p, 24'hFEFE01);
            end
        end

        // All four requesting continuously from ptr=0.
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_a[i*AW +: AW] = AW'(100 + i);
            req_b[i*BW +: BW] = BW'(3);
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge ap_clk);
            chk("t2_grant", req_ready == (N'(1) << (k % 4)), req_ready, N'(1) << (k % 4));
            if (k >= LAT) begin
                chk("t2_id", rsp_id == IW'((k - LAT) % 4), rsp_id, (k - LAT) % 4);
                chk("t2_prod", rsp_p == PW'((100 + (k - LAT) % 4) * 3), rsp_p, (100 + (k - LAT) % 4) * 3);
            end
            step();
        end
        drain();

        // Backpressure while FULL with 3*5.
        req_a[0 +: AW] = AW'(3);
        req_b[0 +: BW] = BW'(5);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (LAT - 1) step();
        req_valid = 4'b1111;
        for (int j = 0; j < 3; j++) begin
            @(negedge ap_clk);
            chk("t3_valid", rsp_valid == 1'b1, rsp_valid, 1);
            chk("t3_prod", rsp_p == 24'd15, rsp_p, 15);
            chk("t3_id", rsp_id == 2'd0, rsp_id, 0);
            chk("t3_stall_ready", req_ready == ((LAT == 2 && j == 0) ? 4'b0010 : 4'b0000),
                req_ready, (LAT == 2 && j == 0) ? 2 : 0);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge ap_clk);
        chk("t3_release", req_ready == ((LAT == 1) ? 4'b0010 : 4'b0100), req_ready, (LAT == 1) ? 2 : 4);
        step();
        drain();

        // Requester 1 drops before its grant.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req_valid = t4_vld[k];
            @(negedge ap_clk);
            chk("t4_grant", req_ready == t4_exp[k], req_ready, t4_exp[k]);
            step();
        end
        drain();

        // Asynchronous reset while a product is held.
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        step();
        req_valid = '0;
        repeat (LAT - 1) step();
        @(negedge ap_clk);
        chk("t5_held", rsp_valid == 1'b1, rsp_valid, 1);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("t5_async_valid", rsp_valid == 1'b0, rsp_valid, 0);
        chk("t5_async_busy", busy == 1'b0, busy, 0);
        @(negedge ap_clk);
        step();
        ap_rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge ap_clk);
        chk("t5_no_ghost", rsp_valid == 1'b0, rsp_valid, 0);
        step();
        req_valid = 4'b1111;
        @(negedge ap_clk);
        chk("t5_first_grant", req_ready == 4'b0001, req_ready, 1);
        step();
        drain();

        // Random traffic.
        repeat (10000) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (req_valid[i]) begin
                    if ($urandom_range(99) < 15) req_valid[i] = 1'b0;
                end else if ($urandom_range(99) < 50) begin
                    req_valid[i] = 1'b1;
                end
            end
            req_a = {$urandom, $urandom};
            req_b = 36'({$urandom, $urandom});
            if ($urandom_range(7) == 0) req_a = '1;
            if ($urandom_range(7) == 0) req_b = '1;
            rsp_ready = ($urandom_range(99) < 70);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (LAT + 2) step();
        @(negedge ap_clk);
        chk("final_queue_empty", q.size() == 0, q.size(), 0);
        chk("final_busy", busy == 1'b0, busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
